// File: rtl/avalon_pio_gpio.sv
// Avalon-MM GPIO slave: WIDTH-bit output register with atomic set/clear,
// synchronised inputs with sticky edge capture and a maskable level interrupt.
module avalon_pio_gpio #(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int          EDGE_TYPE   = 0,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);
    localparam int            CW      = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0] ARM_CNT = CW'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] s, prev_q, edge_raw, edge_det, wd;
    logic [WIDTH-1:0] data_out, data_out_nxt, irq_mask, irq_mask_nxt, edge_cap, edge_cap_nxt, clr;
    logic [CW-1:0]    arm_cnt;
    logic             armed, wr_en, rd_en;
    logic [31:0]      rd_nxt;

    assign s        = sync_q[SYNC_STAGES-1];
    assign wd       = writedata[WIDTH-1:0];
    assign wr_en    = chipselect & ~write_n;
    assign rd_en    = chipselect & write_n;
    assign armed    = (arm_cnt == ARM_CNT);
    assign out_port = data_out;

    generate
        if (WIDTH < 32) begin : g_wd_hi
            logic unused_wd_hi;
            assign unused_wd_hi = ^writedata[31:WIDTH];
        end
        if (EDGE_TYPE == 0) begin : g_rise
            assign edge_raw = s & ~prev_q;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign edge_raw = ~s & prev_q;
        end else begin : g_any
            assign edge_raw = s ^ prev_q;
        end
    endgenerate

    // Edges are ignored until the sync chain and history hold post-reset samples,
    // so inputs held high through reset do not look like rising edges.
    assign edge_det = armed ? edge_raw : '0;

    always_comb begin
        data_out_nxt = data_out;
        irq_mask_nxt = irq_mask;
        clr          = '0;
        if (wr_en) begin
            case (address)
                3'd0:    data_out_nxt = wd;
                3'd2:    irq_mask_nxt = wd;
                3'd3:    clr          = wd;
                3'd4:    data_out_nxt = data_out | wd;
                3'd5:    data_out_nxt = data_out & ~wd;
                default: ;
            endcase
        end
        // A new edge wins over a simultaneous write-1-to-clear.
        edge_cap_nxt = (edge_cap & ~clr) | edge_det;
    end

    always_comb begin
        rd_nxt = '0;
        case (address)
            3'd0:    rd_nxt[WIDTH-1:0] = s;
            3'd1:    rd_nxt[WIDTH-1:0] = data_out;
            3'd2:    rd_nxt[WIDTH-1:0] = irq_mask;
            3'd3:    rd_nxt[WIDTH-1:0] = edge_cap;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            prev_q   <= '0;
            arm_cnt  <= '0;
            data_out <= RESET_VALUE[WIDTH-1:0];
            irq_mask <= '0;
            edge_cap <= '0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            for (int i = SYNC_STAGES - 1; i > 0; i--) sync_q[i] <= sync_q[i-1];
            sync_q[0] <= in_port;
            prev_q    <= s;
            if (!armed) arm_cnt <= arm_cnt + 1'b1;
            data_out  <= data_out_nxt;
            irq_mask  <= irq_mask_nxt;
            edge_cap  <= edge_cap_nxt;
            irq       <= |(edge_cap & irq_mask);
            if (rd_en) readdata <= rd_nxt;
        end
    end
endmodule
